prim_sel_arb: RTL and testbench

PRIM_SEL_ARB -- requirements
Module: prim_sel_arb

---
 rtl/prim_pkg.sv | 27 ++
 rtl/prim_rr_pick.sv | 37 +++
 rtl/prim_sel_arb.sv | 134 +++++++++++++
 tb/tb_prim_sel_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_pkg.sv
// Shared constants and types for the primitive select arbiter and its
// round-robin picker.
package prim_pkg;

    localparam int N_PRIM_DEF = 19;
    localparam int PRIM_IDX_W = 5;
    localparam int GAP_W      = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Round-robin successor of idx among n lines.
    function automatic logic [PRIM_IDX_W-1:0] next_idx(
        input logic [PRIM_IDX_W-1:0] idx,
        input int                    n
    );
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + PRIM_IDX_W'(1);
    endfunction

endpackage

// File: rtl/prim_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or above ptr,
// searching upward and wrapping modulo N_PRIM.
module prim_rr_pick
    import prim_pkg::*;
#(
    parameter int N_PRIM = N_PRIM_DEF
) (
    input  logic [N_PRIM-1:0]     pending,
    input  logic [PRIM_IDX_W-1:0] ptr,
    output logic [N_PRIM-1:0]     pick,
    output logic [PRIM_IDX_W-1:0] idx,
    output logic                  found
);

    always_comb begin
        int                    pos;
        logic [PRIM_IDX_W-1:0] pos_idx;
        pick    = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N_PRIM; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_PRIM) begin
                pos = pos - N_PRIM;
            end
            pos_idx = PRIM_IDX_W'(pos);
            if (!found && pending[pos_idx]) begin
                found         = 1'b1;
                pick[pos_idx] = 1'b1;
                idx           = pos_idx;
            end
        end
    end

endmodule

// File: rtl/prim_sel_arb.sv
// Round-robin arbiter that offers one registered one-hot primitive select at
// a time, holds it until accepted, then idles for GAP_CYC cycles.
module prim_sel_arb
    import prim_pkg::*;
#(
    parameter int N_PRIM  = N_PRIM_DEF,
    parameter int GAP_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PRIM-1:0]     req,
    output logic [N_PRIM-1:0]     sel_prim,
    output logic [PRIM_IDX_W-1:0] sel_idx,
    output logic                  sel_valid,
    input  logic                  sel_ready,
    output logic                  pend_any,
    output logic [CNT_W-1:0]      grant_cnt
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic [N_PRIM-1:0]     pending_q;
    logic [N_PRIM-1:0]     pending_d;
    logic [N_PRIM-1:0]     clr_mask;
    logic [PRIM_IDX_W-1:0] ptr_q;
    logic [GAP_W-1:0]      gap_q;
    logic [GAP_W-1:0]      gap_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [N_PRIM-1:0]     sel_prim_q;
    logic [PRIM_IDX_W-1:0] sel_idx_q;
    logic [N_PRIM-1:0]     pick;
    logic [PRIM_IDX_W-1:0] pick_idx;
    logic                  pick_found;
    logic                  xfer;
    logic                  load_sel;

    assign xfer      = (state_q == OFFER) && sel_ready;
    assign clr_mask  = xfer ? sel_prim_q : '0;
    // A new request wins over the clear of the granted bit.
    assign pending_d = (pending_q & ~clr_mask) | req;

    // The picker sees this cycle's requests so a late arrival in IDLE still competes.
    prim_rr_pick #(
        .N_PRIM (N_PRIM)
    ) u_pick (
        .pending (pending_d),
        .ptr     (ptr_q),
        .pick    (pick),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        load_sel = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((|pending_q) && pick_found) begin
                    state_d  = OFFER;
                    load_sel = 1'b1;
                end
            end
            OFFER: begin
                if (sel_ready) begin
                    if (GAP_CYC > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
        end
    end

    // The select is frozen for the whole offer and dropped on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_prim_q <= '0;
            sel_idx_q  <= '0;
        end else if (load_sel) begin
            sel_prim_q <= pick;
            sel_idx_q  <= pick_idx;
        end else if (xfer) begin
            sel_prim_q <= '0;
            sel_idx_q  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (xfer) begin
            ptr_q <= next_idx(sel_idx_q, N_PRIM);
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign sel_prim  = sel_prim_q;
    assign sel_idx   = sel_idx_q;
    assign sel_valid = (state_q == OFFER);
    assign pend_any  = |pending_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_prim_sel_arb.sv
// Directed bench for prim_sel_arb: one instance with the default gap, one with
// no gap; expected grant indices are queued and matched on every transfer.
module tb_prim_sel_arb;
    import prim_pkg::*;

    localparam int N = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [N-1:0]          req;
    logic                  sel_ready;
    logic [N-1:0]          sel_prim;
    logic [PRIM_IDX_W-1:0] sel_idx;
    logic                  sel_valid;
    logic                  pend_any;
    logic [CNT_W-1:0]      grant_cnt;

    logic [N-1:0]          req0;
    logic                  sel_ready0;
    logic [N-1:0]          sel_prim0;
    logic [PRIM_IDX_W-1:0] sel_idx0;
    logic                  sel_valid0;
    logic                  pend_any0;
    logic [CNT_W-1:0]      grant_cnt0;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int exp0_q[$];
    int e_main;
    int e_zero;
    bit chk_en = 1'b0;

    prim_sel_arb #(.N_PRIM(N), .GAP_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel_prim  (sel_prim),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .pend_any  (pend_any),
        .grant_cnt (grant_cnt)
    );

    prim_sel_arb #(.N_PRIM(N), .GAP_CYC(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req       (req0),
        .sel_prim  (sel_prim0),
        .sel_idx   (sel_idx0),
        .sel_valid (sel_valid0),
        .sel_ready (sel_ready0),
        .pend_any  (pend_any0),
        .grant_cnt (grant_cnt0)
    );

    function automatic logic [N-1:0] bit_of(input int i);
        return N'(1) << i;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string tag, input bit use0, input int budget);
        int left = budget;
        while (left > 0 && (use0 ? exp0_q.size() : exp_q.size()) > 0) begin
            tick(1);
            left--;
        end
        check_output(tag, use0 ? exp0_q.size() : exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("onehot", 32'($countones(sel_prim)), sel_valid ? 1 : 0);
            if (!sel_valid) check_output("idle_idx", sel_idx, 0);
            if (sel_valid && sel_ready) begin
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_err++;
                    $error("[TB] FAIL sb_unexpected observed idx=%0d expected=none", sel_idx);
                end
                if (exp_q.size() > 0) begin
                    e_main = exp_q.pop_front();
                    check_output("sb_idx", sel_idx, e_main);
                    check_output("sb_prim", sel_prim, 32'(bit_of(e_main)));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("onehot0", 32'($countones(sel_prim0)), sel_valid0 ? 1 : 0);
            if (sel_valid0 && sel_ready0) begin
                n_cmp++;
                assert (exp0_q.size() > 0) else begin
                    n_err++;
                    $error("[TB] FAIL sb0_unexpected observed idx=%0d expected=none", sel_idx0);
                end
                if (exp0_q.size() > 0) begin
                    e_zero = exp0_q.pop_front();
                    check_output("sb0_idx", sel_idx0, e_zero);
                    check_output("sb0_prim", sel_prim0, 32'(bit_of(e_zero)));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; sel_ready = 1'b0; req0 = '0; sel_ready0 = 1'b0;
        tick(2);
        chk_en = 1'b1;
        check_output("rst_valid", sel_valid, 0);
        check_output("rst_prim", sel_prim, 0);
        check_output("rst_idx", sel_idx, 0);
        check_output("rst_pend", pend_any, 0);
        check_output("rst_cnt", grant_cnt, 0);

        // Reset during an offer of idx 9; a request under reset is ignored.
        rst = 1'b0; req = bit_of(9);
        tick(1);
        req = '0;
        check_output("r9_pend", pend_any, 1);
        check_output("r9_idle", sel_valid, 0);
        tick(1);
        check_output("r9_valid", sel_valid, 1);
        check_output("r9_idx", sel_idx, 9);
        rst = 1'b1; req = bit_of(4);
        tick(1);
        check_output("r9_rst_valid", sel_valid, 0);
        check_output("r9_rst_pend", pend_any, 0);
        check_output("r9_rst_cnt", grant_cnt, 0);
        rst = 1'b0; req = '0;
        tick(1);
        check_output("rst_req_ignored", pend_any, 0);

        // Single pulse on idx 5: two-cycle latency, then a two-cycle gap.
        sel_ready = 1'b1;
        req = bit_of(5); exp_q.push_back(5);
        tick(1);
        req = '0;
        check_output("lat_idle", sel_valid, 0);
        tick(1);
        check_output("lat_valid", sel_valid, 1);
        check_output("lat_prim", sel_prim, 32'h20);
        check_output("lat_idx", sel_idx, 5);
        tick(1);
        check_output("gap1_valid", sel_valid, 0);
        check_output("gap1_cnt", grant_cnt, 1);
        req = bit_of(6); exp_q.push_back(6);
        tick(1);
        req = '0;
        check_output("gap2_valid", sel_valid, 0);
        check_output("gap2_prim", sel_prim, 0);
        tick(1);
        check_output("gap_idle_valid", sel_valid, 0);
        tick(1);
        check_output("after_gap_valid", sel_valid, 1);
        check_output("after_gap_idx", sel_idx, 6);
        tick(1);
        check_output("cnt2", grant_cnt, 2);
        tick(2);

        // Hold idx 7 for ten cycles while req[2] toggles, then re-request 7.
        sel_ready = 1'b0;
        req = bit_of(7); exp_q.push_back(7);
        tick(1);
        req = '0;
        tick(1);
        check_output("hold_first_prim", sel_prim, 32'h80);
        for (int i = 0; i < 9; i++) begin
            req = (i % 2 == 0) ? bit_of(2) : N'(0);
            tick(1);
            check_output("hold_valid", sel_valid, 1);
            check_output("hold_prim", sel_prim, 32'h80);
            check_output("hold_idx", sel_idx, 7);
        end
        sel_ready = 1'b1;
        req = bit_of(7);
        exp_q.push_back(2); exp_q.push_back(7);
        tick(1);
        req = '0;
        check_output("rereq_valid", sel_valid, 0);
        check_output("rereq_pend", pend_any, 1);
        check_output("rereq_cnt", grant_cnt, 3);
        tick(3);
        check_output("next2_valid", sel_valid, 1);
        check_output("next2_idx", sel_idx, 2);
        tick(4);
        check_output("regrant7_valid", sel_valid, 1);
        check_output("regrant7_idx", sel_idx, 7);
        wait_drain("drain_hold", 1'b0, 10);
        tick(2);
        check_output("hold_pend_clear", pend_any, 0);

        // Move ptr to 18, then pend 3 and 17 together to exercise the wrap.
        req = bit_of(17); exp_q.push_back(17);
        tick(1);
        req = '0;
        wait_drain("drain_17", 1'b0, 10);
        req = bit_of(3) | bit_of(17);
        exp_q.push_back(3); exp_q.push_back(17);
        tick(1);
        req = '0;
        wait_drain("drain_wrap", 1'b0, 30);
        tick(3);
        check_output("cnt8", grant_cnt, 8);

        // Saturation of the grant counter.
        force dut.cnt_q = 16'hFFFF;
        tick(1);
        release dut.cnt_q;
        tick(1);
        check_output("sat_preload", grant_cnt, 32'hFFFF);
        req = bit_of(0); exp_q.push_back(0);
        tick(1);
        req = '0;
        wait_drain("drain_sat", 1'b0, 10);
        tick(1);
        check_output("sat_hold", grant_cnt, 32'hFFFF);
        tick(3);

        // Zero-gap instance: all requests held, grants sweep 0..18 and wrap.
        for (int i = 0; i < N; i++) exp0_q.push_back(i);
        exp0_q.push_back(0);
        sel_ready0 = 1'b1; req0 = '1;
        wait_drain("drain_rr", 1'b1, 80);
        sel_ready0 = 1'b0; req0 = '0;
        tick(1);
        check_output("rr_cnt", grant_cnt0, 20);
        check_output("rr_pend", pend_any0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
